gp_reg_bank: RTL



---
 rtl/gp_reg_pkg.sv | 25 ++
 rtl/gp_reg_xchg_ctrl.sv | 74 +++++++
 rtl/gp_reg_bank.sv | 133 +++++++++++++
 3 files changed

// File: rtl/gp_reg_pkg.sv
// Shared types and constants for the general-purpose register bank.
// Covers the XCHG sequencer states, the legacy register names and the default sizes.
package gp_reg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWAP1 = 2'd1,
        SWAP2 = 2'd2
    } xchg_state_t;

    // Where an exchange write takes its data from
    typedef enum logic {
        SRC_REG = 1'b0,
        SRC_TMP = 1'b1
    } xchg_src_t;

    localparam int REG_AL = 0;
    localparam int REG_BL = 1;
    localparam int REG_CL = 2;
    localparam int REG_DL = 3;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

endpackage

// File: rtl/gp_reg_xchg_ctrl.sv
// Two-cycle register exchange sequencer: latches the indices and emits one write strobe per cycle.
// SWAP1 copies reg[b] into reg[a]; SWAP2 writes the saved tmp into reg[b].
module gp_reg_xchg_ctrl
    import gp_reg_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          xchg_req_i,
    input  logic [AW-1:0] xchg_a_i,
    input  logic [AW-1:0] xchg_b_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          cap_o,
    output logic          wr_o,
    output logic [AW-1:0] wr_idx_o,
    output logic [AW-1:0] src_idx_o,
    output xchg_src_t     wr_src_o,
    output xchg_state_t   state_o
);

    xchg_state_t   state_q, state_d;
    logic [AW-1:0] a_q, a_d;
    logic [AW-1:0] b_q, b_d;
    logic          accept;

    // Out-of-range requests are dropped without leaving IDLE
    assign accept = (state_q == IDLE) && xchg_req_i
                    && (int'(xchg_a_i) < DEPTH) && (int'(xchg_b_i) < DEPTH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SWAP1;
                    a_d     = xchg_a_i;
                    b_d     = xchg_b_i;
                end
            end
            SWAP1:   state_d = SWAP2;
            SWAP2:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o    = (state_q != IDLE);
        done_o    = (state_q == SWAP2);
        cap_o     = accept;
        wr_o      = (state_q == SWAP1) || (state_q == SWAP2);
        wr_idx_o  = (state_q == SWAP2) ? b_q : a_q;
        src_idx_o = b_q;
        wr_src_o  = (state_q == SWAP2) ? SRC_TMP : SRC_REG;
        state_o   = state_q;
    end

endmodule

// File: rtl/gp_reg_bank.sv
// DEPTH x WIDTH register file: two combinational read ports with write bypass,
// one write port, an inc/dec port with wrap flag, and a two-cycle exchange sequencer.
module gp_reg_bank
    import gp_reg_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_sel,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_a_en,
    input  logic [AW-1:0]          rd_a_sel,
    output logic [WIDTH-1:0]       rd_a_data,
    input  logic                   rd_b_en,
    input  logic [AW-1:0]          rd_b_sel,
    output logic [WIDTH-1:0]       rd_b_data,
    input  logic                   inc_en,
    input  logic [AW-1:0]          inc_sel,
    input  logic                   inc_dec,
    output logic                   inc_wrap,
    input  logic                   xchg_req,
    input  logic [AW-1:0]          xchg_a,
    input  logic [AW-1:0]          xchg_b,
    output logic                   xchg_busy,
    output logic                   xchg_done,
    output logic [DEPTH*WIDTH-1:0] regs_flat
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [WIDTH-1:0] tmp_q, tmp_d;
    logic [WIDTH-1:0] xchg_src_val;
    logic             inc_wrap_q, inc_wrap_d;
    logic             xchg_idle;
    logic             xchg_cap, xchg_wr;
    logic [AW-1:0]    xchg_wr_idx, xchg_src_idx;
    xchg_src_t        xchg_src;
    xchg_state_t      xchg_state;
    logic             wr_ok, inc_ok;

    gp_reg_xchg_ctrl #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_xchg (
        .clk        (clk),
        .reset      (reset),
        .xchg_req_i (xchg_req),
        .xchg_a_i   (xchg_a),
        .xchg_b_i   (xchg_b),
        .busy_o     (xchg_busy),
        .done_o     (xchg_done),
        .cap_o      (xchg_cap),
        .wr_o       (xchg_wr),
        .wr_idx_o   (xchg_wr_idx),
        .src_idx_o  (xchg_src_idx),
        .wr_src_o   (xchg_src),
        .state_o    (xchg_state)
    );

    // Write and inc/dec are only honoured while the exchange sequencer is idle
    assign xchg_idle = (xchg_state == IDLE);
    assign wr_ok     = wr_en && xchg_idle && (int'(wr_sel) < DEPTH);
    assign inc_ok    = inc_en && xchg_idle && (int'(inc_sel) < DEPTH)
                       && !(wr_ok && (wr_sel == inc_sel));

    function automatic logic [WIDTH-1:0] read_port(input logic en, input logic [AW-1:0] sel);
        logic [WIDTH-1:0] v;
        v = '0;
        if (en) begin
            if (wr_ok && (wr_sel == sel)) begin
                v = wr_data;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (int'(sel) == i) v = regs_q[i];
                end
            end
        end
        return v;
    endfunction

    always_comb begin
        rd_a_data = read_port(rd_a_en, rd_a_sel);
        rd_b_data = read_port(rd_b_en, rd_b_sel);
    end

    always_comb begin
        tmp_d        = tmp_q;
        inc_wrap_d   = 1'b0;
        xchg_src_val = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (int'(xchg_src_idx) == i) xchg_src_val = regs_q[i];
        end
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_ok && (int'(wr_sel) == i)) begin
                regs_d[i] = wr_data;
            end else if (inc_ok && (int'(inc_sel) == i)) begin
                regs_d[i]  = inc_dec ? (regs_q[i] - ONE) : (regs_q[i] + ONE);
                inc_wrap_d = inc_dec ? (regs_q[i] == '0) : (&regs_q[i]);
            end
            if (xchg_wr && (int'(xchg_wr_idx) == i)) begin
                regs_d[i] = (xchg_src == SRC_TMP) ? tmp_q : xchg_src_val;
            end
            // tmp samples the pre-edge value, before any same-edge write or inc
            if (xchg_cap && (int'(xchg_a) == i)) tmp_d = regs_q[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            tmp_q      <= '0;
            inc_wrap_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
            tmp_q      <= tmp_d;
            inc_wrap_q <= inc_wrap_d;
        end
    end

    assign inc_wrap = inc_wrap_q;

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign regs_flat[g*WIDTH +: WIDTH] = regs_q[g];
    end

endmodule
